uart_rx: RTL and testbench

//  Asynchronous serial receiver paired with the UART transmitter; recovers 8N1-style frames from the rx pin.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync_2ff.sv | 35 +++
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and parity helper for the RX and TX sides
//
// Purpose : common oversampling constants and a parity function so that the
//           receiver and transmitter agree on bit timing and parity polarity.
// Contents: OVERSAMPLE - s_tick pulses per bit period
//           MID_TICK   - s value at which the start bit centre is reached
//           parity()   - parity bit for the low n bits of d (odd = 1 inverts)

package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // Returns the parity bit a transmitter would send for the low n bits of d.
    // Even parity: XOR of the bits. Odd parity: its complement.
    function automatic logic parity(input logic [7:0] d, input int n, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchroniser for a single asynchronous input
//
// Purpose : brings an asynchronous level into the clk domain. Both flops reset
//           to RESET_VAL so an idle-high line does not look like an edge after
//           reset is released.
// Ports   : clk     in  system clock
//           reset_n in  asynchronous active-low reset
//           d_i     in  asynchronous input
//           q_o     out synchronised output (2 clk latency)

module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampling UART receiver with frame and parity error flags
//
// Purpose : recovers start/data/[parity]/stop frames from the rx pin, sampling
//           each bit at its centre using the shared s_tick (16x baud) strobe.
// Ports   : clk          in   system clock
//           reset_n      in   asynchronous active-low reset
//           s_tick       in   one-clk pulse at 16x baud
//           rx           in   serial input, asynchronous, idle high
//           rx_data      out  received byte, right-aligned, zero above DBIT-1
//           rx_done_tick out  one-clk pulse when rx_data and flags update
//           frame_err    out  stop bit sampled low (held until next done)
//           parity_err   out  parity mismatch (held until next done)
//           busy         out  high while the receiver is not idle

module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // s must reach SB_TICK-1 in the stop state, so widen it for long stop bits.
    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } state_t;

    logic rx_s;

    uart_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rx),
        .q_o     (rx_s)
    );

    state_t          state_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q;
    logic            par_mis_q;     // parity mismatch captured mid-frame, published at stop
    logic [7:0]      rx_data_q;
    logic            done_q;
    logic            frame_err_q;
    logic            parity_err_q;
    logic            busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            par_mis_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Entry needs no s_tick, so a start edge right after a
                    // stop bit is never missed.
                    if (!rx_s) begin
                        state_q   <= ST_START;
                        s_q       <= '0;
                        par_mis_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                ST_START: begin
                    if (s_tick) begin
                        if (s_q == S_MID) begin
                            if (!rx_s) begin
                                state_q <= ST_DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                // Glitch shorter than half a bit: not a frame.
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (s_tick) begin
                        if (s_q == S_LAST) begin
                            s_q <= '0;
                            b_q <= {rx_s, b_q[DBIT-1:1]};
                            if (n_q == N_LAST) begin
                                state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (s_tick) begin
                        if (s_q == S_LAST) begin
                            s_q       <= '0;
                            state_q   <= ST_STOP;
                            par_mis_q <= parity(8'(b_q), DBIT, ODD) ^ rx_s;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (s_tick) begin
                        if (s_q == S_STOP) begin
                            s_q          <= '0;
                            rx_data_q    <= 8'(b_q);
                            frame_err_q  <= ~rx_s;
                            parity_err_q <= par_mis_q;
                            done_q       <= 1'b1;
                            if (rx_s) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_BRK;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end

                ST_BRK: begin
                    // Line held low after a bad stop bit: wait for it to
                    // return high before looking for another start edge.
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_done_tick = done_q;
    assign frame_err    = frame_err_q;
    assign parity_err   = parity_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed testbench for uart_rx (8N1, even parity, 7-bit variants)

module tb_uart_rx;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic s_tick  = 1'b0;
    logic [1:0] div = 2'd0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;

    logic [7:0] rx_data0, rx_data1, rx_data2;
    logic done0, done1, done2;
    logic fe0, fe1, fe2;
    logic pe0, pe1, pe2;
    logic busy0, busy1, busy2;

    int errors = 0;
    int checks = 0;

    int done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0;
    logic [7:0] last0 = 8'h00, last1 = 8'h00, last2 = 8'h00, prev2 = 8'h00;
    logic lfe0 = 1'b0, lpe1 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div    <= div + 2'd1;
        s_tick <= (div == 2'd3);
    end

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx0),
        .rx_data(rx_data0), .rx_done_tick(done0), .frame_err(fe0),
        .parity_err(pe0), .busy(busy0));

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx1),
        .rx_data(rx_data1), .rx_done_tick(done1), .frame_err(fe1),
        .parity_err(pe1), .busy(busy1));

    uart_rx #(.DBIT(7), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx2),
        .rx_data(rx_data2), .rx_done_tick(done2), .frame_err(fe2),
        .parity_err(pe2), .busy(busy2));

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            done_cnt0 <= done_cnt0 + 1;
            last0     <= rx_data0;
            lfe0      <= fe0;
        end
        if (done1 === 1'b1) begin
            done_cnt1 <= done_cnt1 + 1;
            last1     <= rx_data1;
            lpe1      <= pe1;
        end
        if (done2 === 1'b1) begin
            done_cnt2 <= done_cnt2 + 1;
            last2     <= rx_data2;
            prev2     <= last2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (s_tick !== 1'b1);
        end
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Start bit, nbits data LSB first, optional parity bit, stop level for stop_ticks.
    task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                              input bit par_en, input logic par_bit,
                              input logic stop_bit, input int stop_ticks);
        logic [7:0] d;
        d = data;
        drive(which, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            drive(which, d[i]);
            wait_ticks(16);
        end
        if (par_en) begin
            drive(which, par_bit);
            wait_ticks(16);
        end
        drive(which, stop_bit);
        wait_ticks(stop_ticks);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(rx_data0), 32'h00);
        check("reset_done",    32'(done0),    32'h0);
        check("reset_frame",   32'(fe0),      32'h0);
        check("reset_parity",  32'(pe0),      32'h0);
        check("reset_busy",    32'(busy0),    32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(4);

        // Two back-to-back 8N1 frames as a transmitter would send them
        send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(2);
        check("t1_cnt_a",  32'(done_cnt0), 32'd1);
        check("t1_data_a", 32'(last0),     32'h55);
        check("t1_fe_a",   32'(lfe0),      32'h0);
        send_frame(0, 8'hA3, 8, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(2);
        check("t1_cnt_b",  32'(done_cnt0), 32'd2);
        check("t1_data_b", 32'(last0),     32'hA3);
        check("t1_pe_b",   32'(pe0),       32'h0);

        // False start: low for 4 ticks only
        rx0 = 1'b0;
        wait_ticks(4);
        rx0 = 1'b1;
        wait_ticks(1);
        check("t2_busy_glitch", 32'(busy0), 32'h1);
        wait_ticks(20);
        check("t2_busy_idle", 32'(busy0),     32'h0);
        check("t2_no_done",   32'(done_cnt0), 32'd2);
        send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(2);
        check("t2_cnt",  32'(done_cnt0), 32'd3);
        check("t2_data", 32'(last0),     32'h3C);

        // Stop bit held low for 40 ticks: framing error then break
        send_frame(0, 8'h81, 8, 1'b0, 1'b0, 1'b0, 40);
        check("t3_cnt",      32'(done_cnt0), 32'd4);
        check("t3_data",     32'(last0),     32'h81);
        check("t3_fe",       32'(lfe0),      32'h1);
        check("t3_busy_brk", 32'(busy0),     32'h1);
        rx0 = 1'b1;
        wait_ticks(4);
        check("t3_busy_idle", 32'(busy0), 32'h0);
        send_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(2);
        check("t3_cnt_next",  32'(done_cnt0), 32'd5);
        check("t3_data_next", 32'(last0),     32'h5A);
        check("t3_fe_next",   32'(fe0),       32'h0);

        // Even parity on 0x07: correct bit is 1
        send_frame(1, 8'h07, 8, 1'b1, 1'b0, 1'b1, 16);
        wait_ticks(2);
        check("t4_cnt_bad",  32'(done_cnt1), 32'd1);
        check("t4_data_bad", 32'(last1),     32'h07);
        check("t4_pe_bad",   32'(lpe1),      32'h1);
        send_frame(1, 8'h07, 8, 1'b1, 1'b1, 1'b1, 16);
        wait_ticks(2);
        check("t4_cnt_ok", 32'(done_cnt1), 32'd2);
        check("t4_pe_ok",  32'(lpe1),      32'h0);
        check("t4_fe_ok",  32'(fe1),       32'h0);

        // Reset after three data bits discards the partial byte
        rx0 = 1'b0;
        wait_ticks(16);
        rx0 = 1'b1; wait_ticks(16);
        rx0 = 1'b0; wait_ticks(16);
        rx0 = 1'b1; wait_ticks(16);
        check("t5_busy_mid", 32'(busy0), 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        rx0     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t5_rst_data", 32'(rx_data0), 32'h00);
        check("t5_rst_busy", 32'(busy0),    32'h0);
        check("t5_rst_done", 32'(done0),    32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(20);
        check("t5_no_done", 32'(done_cnt0), 32'd5);
        send_frame(0, 8'hF0, 8, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(2);
        check("t5_cnt",  32'(done_cnt0), 32'd6);
        check("t5_data", 32'(last0),     32'hF0);
        check("t5_fe",   32'(fe0),       32'h0);

        // 7-bit frames, second one with no idle gap
        send_frame(2, 8'h7F, 7, 1'b0, 1'b0, 1'b1, 16);
        send_frame(2, 8'h2A, 7, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(2);
        check("t6_cnt",   32'(done_cnt2), 32'd2);
        check("t6_first", 32'(prev2),     32'h7F);
        check("t6_last",  32'(last2),     32'h2A);
        check("t6_bit7",  32'(rx_data2[7]), 32'h0);
        check("t6_fe",    32'(fe2),       32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
